// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// master drives operands and consumes results; slave is the pipe.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       OP;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] Z;
    logic             ZERO;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [CW-1:0]    COUNT;

    modport master (
        output A, B, OP, IN_VALID, OUT_READY,
        input  IN_READY, Z, ZERO, OUT_VALID, COUNT
    );

    modport slave (
        input  A, B, OP, IN_VALID, OUT_READY,
        output IN_READY, Z, ZERO, OUT_VALID, COUNT
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise AND/OR/XOR/NOR unit with zero flag,
// buffered in a DEPTH-entry FIFO behind valid/ready.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESETN,
    logic_unit_pipe_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic             zero;
        logic [WIDTH-1:0] z;
    } ent_t;

    ent_t             mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res;
    logic             push, pop;

    always_comb begin
        res = '0;
        case (bus.OP)
            2'b00:   res = bus.A & bus.B;
            2'b01:   res = bus.A | bus.B;
            2'b10:   res = bus.A ^ bus.B;
            default: res = ~(bus.A | bus.B);
        endcase
    end

    // Ready depends only on stored count, never on OUT_READY.
    assign bus.IN_READY  = (cnt_q < FULL);
    assign bus.OUT_VALID = (cnt_q != '0);
    assign bus.COUNT     = cnt_q;

    assign push = bus.IN_VALID && bus.IN_READY;
    assign pop  = bus.OUT_VALID && bus.OUT_READY;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_q] <= '{zero: (res == '0), z: res};
        end
    end

    assign bus.Z    = bus.OUT_VALID ? mem_q[rd_q].z    : '0;
    assign bus.ZERO = bus.OUT_VALID ? mem_q[rd_q].zero : 1'b0;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps on an 8x2
// instance, then random traffic on 1x4 and 16x4 instances.
module tb_logic_unit_pipe;
    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK = ~CLK;

    logic_unit_pipe_if #(.WIDTH(8),  .DEPTH(2)) bus8 ();
    logic_unit_pipe_if #(.WIDTH(1),  .DEPTH(4)) bus1 ();
    logic_unit_pipe_if #(.WIDTH(16), .DEPTH(4)) bus16 ();

    logic_unit_pipe #(.WIDTH(8), .DEPTH(2)) dut8 (
        .CLK(CLK), .RESETN(RESETN), .bus(bus8));
    logic_unit_pipe #(.WIDTH(1), .DEPTH(4)) dut1 (
        .CLK(CLK), .RESETN(RESETN), .bus(bus1));
    logic_unit_pipe #(.WIDTH(16), .DEPTH(4)) dut16 (
        .CLK(CLK), .RESETN(RESETN), .bus(bus16));

    typedef int q_t[$];
    q_t q8, q1, q16;
    int passes = 0;
    int checks = 0;

    // Reference entry: result in [15:0], zero flag in bit 16.
    function automatic int f(int a, int b, int op, int w);
        int r;
        case (op & 3)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a ^ b;
            default: r = ~(a | b);
        endcase
        r = r & ((1 << w) - 1);
        return r | ((r == 0) ? (1 << 16) : 0);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(string tag, q_t q, int depth,
                           int z, int zero, int ov, int ir, int cnt);
        int n;
        int h;
        n = q.size();
        h = (n != 0) ? q[0] : 0;
        chk({tag, ".Z"}, z, h & 'hFFFF);
        chk({tag, ".ZERO"}, zero, (h >> 16) & 1);
        chk({tag, ".OUT_VALID"}, ov, (n != 0) ? 1 : 0);
        chk({tag, ".IN_READY"}, ir, (n < depth) ? 1 : 0);
        chk({tag, ".COUNT"}, cnt, n);
    endtask

    // Check current state, predict the next edge, then drive inputs.
    task automatic cyc8(bit v, int a, int b, int op, bit ordy);
        int n;
        @(negedge CLK);
        chk_out("d8", q8, 2, int'(bus8.Z), int'(bus8.ZERO),
                int'(bus8.OUT_VALID), int'(bus8.IN_READY), int'(bus8.COUNT));
        n = q8.size();
        if (v && n < 2) q8.push_back(f(a, b, op, 8));
        if (ordy && n > 0) void'(q8.pop_front());
        bus8.IN_VALID  = v;
        bus8.A         = 8'(a);
        bus8.B         = 8'(b);
        bus8.OP        = v ? 2'(op) : 2'bxx;
        bus8.OUT_READY = ordy;
    endtask

    task automatic cycsw(bit v, int a, int b, int op, bit ordy);
        int n;
        @(negedge CLK);
        chk_out("w1", q1, 4, int'(bus1.Z), int'(bus1.ZERO),
                int'(bus1.OUT_VALID), int'(bus1.IN_READY), int'(bus1.COUNT));
        chk_out("w16", q16, 4, int'(bus16.Z), int'(bus16.ZERO),
                int'(bus16.OUT_VALID), int'(bus16.IN_READY),
                int'(bus16.COUNT));
        n = q1.size();
        if (v && n < 4) q1.push_back(f(a, b, op, 1));
        if (ordy && n > 0) void'(q1.pop_front());
        n = q16.size();
        if (v && n < 4) q16.push_back(f(a, b, op, 16));
        if (ordy && n > 0) void'(q16.pop_front());
        bus1.IN_VALID   = v;
        bus1.A          = 1'(a);
        bus1.B          = 1'(b);
        bus1.OP         = 2'(op);
        bus1.OUT_READY  = ordy;
        bus16.IN_VALID  = v;
        bus16.A         = 16'(a);
        bus16.B         = 16'(b);
        bus16.OP        = 2'(op);
        bus16.OUT_READY = ordy;
    endtask

    initial begin
        bus8.IN_VALID = 0; bus8.OUT_READY = 0;
        bus8.A = 0; bus8.B = 0; bus8.OP = 0;
        bus1.IN_VALID = 0; bus1.OUT_READY = 0;
        bus1.A = 0; bus1.B = 0; bus1.OP = 0;
        bus16.IN_VALID = 0; bus16.OUT_READY = 0;
        bus16.A = 0; bus16.B = 0; bus16.OP = 0;

        #1;
        chk("rst.OUT_VALID", int'(bus8.OUT_VALID), 0);
        chk("rst.Z", int'(bus8.Z), 0);
        chk("rst.ZERO", int'(bus8.ZERO), 0);
        chk("rst.COUNT", int'(bus8.COUNT), 0);
        #7 RESETN = 1'b1;

        // Basic ops, one cycle latency with OUT_READY high
        cyc8(1, 2, 54, 0, 1);
        cyc8(1, 2, 14, 1, 1);
        chk("t1.and", int'(bus8.Z), 2);
        cyc8(1, 'hFF, 'h0F, 2, 1);
        chk("t1.or", int'(bus8.Z), 14);
        cyc8(1, 'hF0, 'h0F, 3, 1);
        chk("t1.xor", int'(bus8.Z), 'hF0);
        cyc8(0, 0, 0, 0, 1);
        chk("t1.nor", int'(bus8.Z), 0);
        chk("t1.nor_zero", int'(bus8.ZERO), 1);
        chk("t1.nor_valid", int'(bus8.OUT_VALID), 1);
        cyc8(0, 0, 0, 0, 0);

        // Backpressure: third op held while full
        cyc8(1, 'hA5, 'h3C, 0, 0);
        cyc8(1, 'h11, 'h22, 1, 0);
        cyc8(1, 'h0F, 'h0F, 2, 0);
        chk("t2.in_ready", int'(bus8.IN_READY), 0);
        chk("t2.count", int'(bus8.COUNT), 2);
        chk("t2.head", int'(bus8.Z), 'h24);
        cyc8(1, 'h0F, 'h0F, 2, 0);
        chk("t2.stable", int'(bus8.Z), 'h24);

        // Drain in order; third op enters after the first pop
        cyc8(1, 'h0F, 'h0F, 2, 1);
        cyc8(1, 'h0F, 'h0F, 2, 1);
        cyc8(0, 0, 0, 0, 1);
        chk("t3.third", int'(bus8.ZERO), 1);
        cyc8(0, 0, 0, 0, 1);
        cyc8(0, 0, 0, 0, 1);
        chk("t3.empty", int'(bus8.OUT_VALID), 0);

        // Simultaneous push/pop at COUNT=1
        cyc8(1, $urandom, $urandom, $urandom, 0);
        for (int i = 0; i < 20; i++) begin
            cyc8(1, $urandom, $urandom, $urandom, 1);
            chk("t4.count", int'(bus8.COUNT), 1);
        end
        cyc8(0, 0, 0, 0, 1);
        cyc8(0, 0, 0, 0, 0);

        // Async reset with two results buffered
        cyc8(1, 'h5A, 'hFF, 0, 0);
        cyc8(1, 'h00, 'h81, 1, 0);
        cyc8(0, 0, 0, 0, 0);
        #2 RESETN = 1'b0;
        #1;
        chk("t5.OUT_VALID", int'(bus8.OUT_VALID), 0);
        chk("t5.Z", int'(bus8.Z), 0);
        chk("t5.ZERO", int'(bus8.ZERO), 0);
        chk("t5.COUNT", int'(bus8.COUNT), 0);
        q8.delete();
        #1 RESETN = 1'b1;
        cyc8(1, 'hC3, 'h3C, 2, 1);
        cyc8(0, 0, 0, 0, 1);
        chk("t5.lat_z", int'(bus8.Z), 'hFF);
        chk("t5.lat_valid", int'(bus8.OUT_VALID), 1);
        cyc8(0, 0, 0, 0, 0);

        // Random traffic on WIDTH=1 and WIDTH=16, DEPTH=4
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit r;
            v = ($urandom_range(0, 3) != 0);
            r = ((i % 64) < 16) ? 1'b0 : ($urandom_range(0, 2) != 0);
            cycsw(v, $urandom, $urandom, $urandom, r);
        end
        for (int i = 0; i < 6; i++) cycsw(0, 0, 0, 0, 1);
        cycsw(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
